// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_pkg
// Purpose  : Shared address map, MMIO register indices, TIMER_CTRL bit
//            positions and timer FSM encoding for the data-memory responder.
// Revision : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

  // Region selects compare against addr[31:16]
  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] MMIO_BASE = 16'hFFFF;

  // MMIO register word index = addr[4:2] (byte offset / 4)
  localparam logic [2:0] MMIO_GPIO_OUT   = 3'd0;  // 0x00 rw
  localparam logic [2:0] MMIO_GPIO_IN    = 3'd1;  // 0x04 ro
  localparam logic [2:0] MMIO_TIMER_CNT  = 3'd2;  // 0x08 ro
  localparam logic [2:0] MMIO_TIMER_CMP  = 3'd3;  // 0x0C rw
  localparam logic [2:0] MMIO_TIMER_CTRL = 3'd4;  // 0x10 rw

  // TIMER_CTRL bit positions
  localparam int CTRL_W    = 4;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_FLAG = 2;
  localparam int CTRL_IE   = 3;

  typedef enum logic {
    TIMER_IDLE = 1'b0,
    TIMER_RUN  = 1'b1
  } timer_state_e;

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_if
// Purpose  : Core data-memory port: write strobe, byte address, store data
//            and combinational load data.
// Revision : 1.0  initial release
// ============================================================================
interface data_mem_responder_if;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output addr, output writedata, input readdata);
  modport slave  (input memwrite, input addr, input writedata, output readdata);
endinterface
`default_nettype wire

// File: rtl/data_mem_responder_mmio_timer.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder_mmio_timer
// Purpose  : 32-bit compare timer with one-shot / autoreload modes, W1C flag
//            and level IRQ. Only built when DMEM_TIMER_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder_mmio_timer
  import data_mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cmp_we,
  input  logic              ctrl_we,
  input  logic [31:0]       wdata,
  output logic [31:0]       cnt,
  output logic [31:0]       cmp,
  output logic [CTRL_W-1:0] ctrl,
  output logic              irq
);

  timer_state_e      state, state_next;
  logic [31:0]       cnt_next;
  logic [CTRL_W-1:0] ctrl_next;
  logic              match;

  assign match = (cnt == cmp);
  assign irq   = ctrl[CTRL_FLAG] & ctrl[CTRL_IE];

  // State, counter, compare and control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= TIMER_IDLE;
      cnt   <= '0;
      cmp   <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ctrl  <= ctrl_next;
      if (cmp_we) cmp <= wdata;
    end
  end

  // Next-state: register writes first, then the timer's own events, so an
  // expiry flag set overrides a same-cycle W1C and a one-shot expiry clears en
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    ctrl_next  = ctrl;
    if (ctrl_we) begin
      ctrl_next[CTRL_EN] = wdata[CTRL_EN];
      ctrl_next[CTRL_AR] = wdata[CTRL_AR];
      ctrl_next[CTRL_IE] = wdata[CTRL_IE];
      if (wdata[CTRL_FLAG]) ctrl_next[CTRL_FLAG] = 1'b0;
    end
    case (state)
      TIMER_IDLE: begin
        if (ctrl_we && wdata[CTRL_EN]) begin
          state_next = TIMER_RUN;
          // restart after a one-shot expiry; otherwise resume from held count
          if (match) cnt_next = '0;
        end
      end
      TIMER_RUN: begin
        if (match) ctrl_next[CTRL_FLAG] = 1'b1;
        if (ctrl_we && !wdata[CTRL_EN]) begin
          state_next = TIMER_IDLE;
        end else if (match) begin
          if (ctrl[CTRL_AR]) begin
            cnt_next = '0;
          end else begin
            ctrl_next[CTRL_EN] = 1'b0;
            state_next         = TIMER_IDLE;
          end
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      default: state_next = TIMER_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Data-memory responder for a single-cycle core: word RAM with
//            aliasing, GPIO out/in registers and an optional compare timer.
//            Define DMEM_TIMER_EN to build the timer; otherwise its registers
//            read 0, ignore writes, and timer_irq is tied low.
// Revision : 1.0  initial release
// ============================================================================
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_AW = 6,
  parameter int GPIO_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  data_mem_responder_if.slave bus,
  input  logic [GPIO_W-1:0]   gpio_in,
  output logic [GPIO_W-1:0]   gpio_out,
  output logic                timer_irq
);

  logic              ram_sel;
  logic              mmio_sel;
  logic              mmio_we;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        mmio_off;
  logic [31:0]       ram [2**RAM_AW];
  logic [GPIO_W-1:0] gpio_sync1;
  logic [GPIO_W-1:0] gpio_sync2;
  logic [31:0]       timer_cnt;
  logic [31:0]       timer_cmp;
  logic [CTRL_W-1:0] timer_ctrl;
  logic [31:0]       rdata;
  logic              unused_addr_bits;

  assign ram_sel  = (bus.addr[31:16] == RAM_BASE);
  assign mmio_sel = (bus.addr[31:16] == MMIO_BASE);
  assign ram_idx  = bus.addr[RAM_AW+1:2];
  assign mmio_off = bus.addr[4:2];
  assign mmio_we  = bus.memwrite & mmio_sel;

  // Byte-lane bits and RAM offset bits above the index alias away
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[15:RAM_AW+2]};

  // RAM word write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (bus.memwrite && ram_sel) ram[ram_idx] <= bus.writedata;
  end

  // GPIO output register and two-flop input synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
    end else begin
      if (mmio_we && (mmio_off == MMIO_GPIO_OUT)) gpio_out <= bus.writedata[GPIO_W-1:0];
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
    end
  end

`ifdef DMEM_TIMER_EN
  data_mem_responder_mmio_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .cmp_we  (mmio_we && (mmio_off == MMIO_TIMER_CMP)),
    .ctrl_we (mmio_we && (mmio_off == MMIO_TIMER_CTRL)),
    .wdata   (bus.writedata),
    .cnt     (timer_cnt),
    .cmp     (timer_cmp),
    .ctrl    (timer_ctrl),
    .irq     (timer_irq)
  );
`else
  assign timer_cnt  = '0;
  assign timer_cmp  = '0;
  assign timer_ctrl = '0;
  assign timer_irq  = 1'b0;
`endif

  // Combinational load data so the core finishes loads in one cycle
  always_comb begin
    rdata = '0;
    if (ram_sel) begin
      rdata = ram[ram_idx];
    end else if (mmio_sel) begin
      case (mmio_off)
        MMIO_GPIO_OUT:   rdata[GPIO_W-1:0] = gpio_out;
        MMIO_GPIO_IN:    rdata[GPIO_W-1:0] = gpio_sync2;
        MMIO_TIMER_CNT:  rdata = timer_cnt;
        MMIO_TIMER_CMP:  rdata = timer_cmp;
        MMIO_TIMER_CTRL: rdata[CTRL_W-1:0] = timer_ctrl;
        default:         rdata = '0;
      endcase
    end
  end

  assign bus.readdata = rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed scenarios plus randomized traffic against a behavioural
//            model of the responder's memory map and timer.
// Revision : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

`ifdef DMEM_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;

  data_mem_responder_if bus ();

  data_mem_responder #(.RAM_AW(6), .GPIO_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit [31:0] m_ram   [64];
  bit        m_valid [64];
  bit [7:0]  m_gpio, m_s1, m_s2;
  bit [31:0] m_cnt, m_cmp;
  bit        m_en, m_ar, m_flag, m_ie;

  bit [7:0]    gin_cur;
  logic [31:0] last_rd;
  logic [7:0]  last_gpio;
  logic        last_irq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] te(input logic [31:0] v);
    return TIMER_EN ? v : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_gpio = 8'd0; m_s1 = 8'd0; m_s2 = 8'd0;
    m_cnt = 32'd0; m_cmp = 32'd0;
    m_en = 1'b0; m_ar = 1'b0; m_flag = 1'b0; m_ie = 1'b0;
  endtask

  task automatic model_read(input bit [31:0] a, output bit [31:0] v, output bit known);
    known = 1'b1;
    v     = 32'd0;
    if (a[31:16] == 16'h0000) begin
      known = m_valid[a[7:2]];
      v     = m_ram[a[7:2]];
    end else if (a[31:16] == 16'hFFFF) begin
      case (a[4:2])
        3'd0:    v = {24'd0, m_gpio};
        3'd1:    v = {24'd0, m_s2};
        3'd2:    v = te(m_cnt);
        3'd3:    v = te(m_cmp);
        3'd4:    v = te({28'd0, m_ie, m_flag, m_ar, m_en});
        default: v = 32'd0;
      endcase
    end
  endtask

  // One rising edge of the responder, from the register-level rules
  task automatic model_clock(input bit we, input bit [31:0] a, input bit [31:0] wd, input bit [7:0] gin);
    bit        match;
    bit [31:0] n_cnt;
    bit        n_en, n_flag;
    match  = (m_cnt == m_cmp);
    n_cnt  = m_cnt;
    n_en   = m_en;
    n_flag = m_flag;
    if (TIMER_EN && m_en) begin
      if (match) begin
        n_flag = 1'b1;
        if (m_ar) n_cnt = 32'd0;
        else      n_en  = 1'b0;
      end else begin
        n_cnt = m_cnt + 32'd1;
      end
    end
    m_s2 = m_s1;
    m_s1 = gin;
    if (we && a[31:16] == 16'h0000) begin
      m_ram[a[7:2]]   = wd;
      m_valid[a[7:2]] = 1'b1;
    end
    if (we && a[31:16] == 16'hFFFF) begin
      if (a[4:2] == 3'd0) m_gpio = wd[7:0];
      if (TIMER_EN && a[4:2] == 3'd3) m_cmp = wd;
      if (TIMER_EN && a[4:2] == 3'd4) begin
        if (m_en && !wd[0]) begin
          n_en  = 1'b0;
          n_cnt = m_cnt;
        end else if (!m_en && wd[0]) begin
          n_en = 1'b1;
          if (match) n_cnt = 32'd0;
        end
        m_ar = wd[1];
        m_ie = wd[3];
        if (wd[2] && !(m_en && match)) n_flag = 1'b0;
      end
    end
    m_cnt  = n_cnt;
    m_en   = n_en;
    m_flag = n_flag;
  endtask

  // Entered and left on a falling edge; samples 1ns after driving
  task automatic cycle(input bit we, input bit [31:0] a, input bit [31:0] wd);
    bit [31:0] exp_rd;
    bit        known;
    bus.memwrite  = we;
    bus.addr      = a;
    bus.writedata = wd;
    gpio_in       = gin_cur;
    #1;
    last_rd   = bus.readdata;
    last_gpio = gpio_out;
    last_irq  = timer_irq;
    model_read(a, exp_rd, known);
    if (known) check("readdata", last_rd, exp_rd);
    check("gpio_out", 32'(last_gpio), 32'(m_gpio));
    check("timer_irq", 32'(last_irq), 32'(TIMER_EN & m_flag & m_ie));
    @(posedge clk);
    model_clock(we, a, wd, gin_cur);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges while the timer is counting
  task automatic reset_pulse();
    bus.memwrite = 1'b0;
    bus.addr     = 32'hFFFF0008;
    gpio_in      = gin_cur;
    #1;
    check("pre_rst_cnt", bus.readdata, te(32'd2));
    check("pre_rst_irq", 32'(timer_irq), te(32'd1));
    #1 reset = 1'b0;
    #1;
    check("rst_irq", 32'(timer_irq), 32'd0);
    check("rst_gpio_out", 32'(gpio_out), 32'd0);
    check("rst_cnt", bus.readdata, 32'd0);
    bus.addr = 32'hFFFF0010;
    #1 check("rst_ctrl", bus.readdata, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit [31:0]   a, wd;
    bit          we;
    int unsigned sel;

    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.addr      = 32'd0;
    bus.writedata = 32'd0;
    gin_cur       = 8'd0;
    gpio_in       = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("init_gpio_out", 32'(gpio_out), 32'd0);
    check("init_irq", 32'(timer_irq), 32'd0);
    bus.addr = 32'hFFFF0010;
    #1 check("init_ctrl", bus.readdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // RAM write/read and aliasing
    cycle(1'b1, 32'h0000_0010, 32'hDEADBEEF);
    cycle(1'b1, 32'h0000_0014, 32'h12345678);
    cycle(1'b0, 32'h0000_0010, 32'd0);
    check("ram_0x10", last_rd, 32'hDEADBEEF);
    cycle(1'b0, 32'h0000_0014, 32'd0);
    check("ram_0x14", last_rd, 32'h12345678);
    cycle(1'b0, 32'h0000_0110, 32'd0);
    check("ram_alias", last_rd, 32'hDEADBEEF);

    // GPIO out and synchronized GPIO in
    cycle(1'b1, 32'hFFFF_0000, 32'h0000_00A5);
    gin_cur = 8'h3C;
    cycle(1'b0, 32'hFFFF_0004, 32'd0);
    check("gpio_out_a5", 32'(last_gpio), 32'h0000_00A5);
    check("gpio_in_0edge", last_rd, 32'd0);
    cycle(1'b0, 32'hFFFF_0004, 32'd0);
    check("gpio_in_1edge", last_rd, 32'd0);
    cycle(1'b0, 32'hFFFF_0004, 32'd0);
    check("gpio_in_2edge", last_rd, 32'h0000_003C);

    // One-shot: cmp=5, en+ie
    cycle(1'b1, 32'hFFFF_000C, 32'd5);
    cycle(1'b1, 32'hFFFF_0010, 32'h9);
    for (int i = 0; i <= 6; i++) begin
      cycle(1'b0, 32'hFFFF_0008, 32'd0);
      check("os_cnt", last_rd, te((i < 5) ? 32'(i) : 32'd5));
      check("os_irq", 32'(last_irq), te((i == 6) ? 32'd1 : 32'd0));
    end
    cycle(1'b0, 32'hFFFF_0010, 32'd0);
    check("os_ctrl", last_rd, te(32'hC));
    cycle(1'b1, 32'hFFFF_0010, 32'h4);
    check("os_irq_before_w1c", 32'(last_irq), te(32'd1));
    cycle(1'b0, 32'hFFFF_0010, 32'd0);
    check("os_irq_after_w1c", 32'(last_irq), 32'd0);

    // Autoreload: cmp equal to held count so enabling restarts from 0
    cycle(1'b1, 32'hFFFF_000C, 32'd5);
    cycle(1'b1, 32'hFFFF_0010, 32'hB);
    cycle(1'b1, 32'hFFFF_000C, 32'd3);
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 32'hFFFF_0008, 32'd0);
      check("ar_cnt", last_rd, te(32'(i)));
    end
    cycle(1'b1, 32'hFFFF_0010, 32'hF);
    check("ar_ctrl_expired", last_rd, te(32'hF));
    check("ar_irq_set", 32'(last_irq), te(32'd1));
    cycle(1'b0, 32'hFFFF_0008, 32'd0);
    check("ar_irq_cleared", 32'(last_irq), 32'd0);
    check("ar_cnt_wrap", last_rd, te(32'd1));
    cycle(1'b0, 32'hFFFF_0008, 32'd0);
    cycle(1'b1, 32'hFFFF_0010, 32'hF);
    cycle(1'b0, 32'hFFFF_0008, 32'd0);
    check("ar_set_wins", 32'(last_irq), te(32'd1));
    check("ar_cnt_reload", last_rd, 32'd0);
    cycle(1'b0, 32'hFFFF_0008, 32'd0);

    // Reset mid-count, then no counting after release
    reset_pulse();
    cycle(1'b0, 32'hFFFF_0008, 32'd0);
    check("post_rst_cnt", last_rd, 32'd0);

    // Unmapped and read-only writes
    cycle(1'b1, 32'h8000_0000, 32'h1234);
    cycle(1'b0, 32'h8000_0000, 32'd0);
    check("unmapped_rd", last_rd, 32'd0);
    cycle(1'b1, 32'hFFFF_0008, 32'h1234);
    cycle(1'b0, 32'hFFFF_0008, 32'd0);
    check("ro_cnt", last_rd, 32'd0);
    cycle(1'b0, 32'hFFFF_0014, 32'd0);
    check("unused_off", last_rd, 32'd0);
    check("gpio_after_unmapped", 32'(last_gpio), 32'd0);

    // Randomized traffic across all regions
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      we  = ($urandom_range(0, 2) == 0);
      wd  = $urandom;
      if (sel < 4) begin
        a = {16'h0000, 16'($urandom)};
      end else if (sel < 8) begin
        a = {16'hFFFF, 16'($urandom)};
        if (a[4:2] == 3'd3) wd = $urandom_range(0, 10);
        if (a[4:2] == 3'd4) wd = $urandom_range(0, 15);
      end else begin
        a = $urandom;
        if (a[31:16] == 16'h0000 || a[31:16] == 16'hFFFF) a[31] = ~a[31];
      end
      if ($urandom_range(0, 7) == 0) gin_cur = 8'($urandom);
      cycle(we, a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
